// File: rtl/proc_mem_responder.sv
// proc_mem_responder: memory-side responder for the multi-cycle processor.
// Serves instruction fetches from a preloaded ROM, LD/ST accesses to a data
// RAM and one memory-mapped output register (LEDR). Every memory action
// happens on the falling edge of clk, so DIN is valid for the processor's
// rising-edge capture within the same T-step.
// Optional feature macro: MEM_STATS_EN adds saturating data-read and
// accepted-write counters on rd_cnt / wr_cnt; without it both read 0.
module proc_mem_responder #(
  parameter int          ROM_AW    = 7,
  parameter int          RAM_AW    = 7,
  parameter logic [15:0] MMIO_ADDR = 16'hFFFF,
  parameter string       ROM_FILE  = "rom.hex",
  parameter string       RAM_FILE  = ""
) (
  input  logic        clk,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        memW,
  input  logic        muxRomRam,
  output logic [15:0] DIN,
  output logic [15:0] LEDR,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [15:0] rom [ROM_DEPTH];
  logic [15:0] ram [RAM_DEPTH];

  // Power-up image of both arrays: all words zero; the ROM is preloaded by
  // the surrounding harness.
  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'h0000;
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = 16'h0000;
  end

  // Decode compares the full 16-bit address so out-of-range accesses can
  // never wrap back into the arrays.
  logic rom_hit, ram_hit, mmio_hit, space_hit;
  logic read_err, write_err, write_ok;

  assign rom_hit   = (ADDR >> ROM_AW) == 16'h0000;
  assign ram_hit   = (ADDR >> RAM_AW) == 16'h0000;
  assign mmio_hit  = (ADDR == MMIO_ADDR) && !ram_hit;
  assign space_hit = ram_hit || mmio_hit;
  assign read_err  = muxRomRam ? !space_hit : !rom_hit;
  assign write_ok  = memW && space_hit;
  assign write_err = memW && !space_hit;

  // Read-data selection for the selected address space.
  logic [15:0] rd_data;
  always_comb begin
    rd_data = 16'h0000;
    if (!muxRomRam) begin
      if (rom_hit) rd_data = rom[ADDR[ROM_AW-1:0]];
    end else if (ram_hit) begin
      rd_data = ram[ADDR[RAM_AW-1:0]];
    end else if (mmio_hit) begin
      rd_data = LEDR;
    end
  end

  // RAM write port; the array itself is left untouched by reset.
  // NOTE: memories get no reset branch -- clearing an array on reset would
  // turn block RAM into a sea of flops, and contents must survive reset.
  always_ff @(negedge clk) begin
    if (!Resetn && memW && ram_hit) ram[ADDR[RAM_AW-1:0]] <= DOUT;
  end

  // Read register, output register and sticky error flag.
  // NOTE: non-blocking assignments let DIN sample the array before the same
  // edge's write lands, which gives read-before-write for free.
  always_ff @(negedge clk or posedge Resetn) begin
    if (Resetn) begin
      DIN  <= 16'h0000;
      LEDR <= 16'h0000;
      err  <= 1'b0;
    end else begin
      DIN <= rd_data;
      if (memW && mmio_hit) LEDR <= DOUT;
      if (read_err || write_err) err <= 1'b1;
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Saturating data-read and accepted-write counters.
  always_ff @(negedge clk or posedge Resetn) begin
    if (Resetn) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else begin
      if (muxRomRam && !memW && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'h0001;
      if (write_ok && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'h0001;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 16'h0000;
  assign wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder: directed bench for proc_mem_responder. A behavioural
// model of the memory map is compared with the DUT every cycle, and literal
// expectations from hand-worked scenarios pin the model itself.
module tb_proc_mem_responder;

  logic        clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] DOUT = 16'h0000;
  logic        memW = 1'b0;
  logic        muxRomRam = 1'b0;
  logic [15:0] DIN, LEDR, rd_cnt, wr_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  proc_mem_responder #(
    .ROM_AW(7), .RAM_AW(7), .MMIO_ADDR(16'hFFFF), .ROM_FILE(""), .RAM_FILE("")
  ) dut (
    .clk(clk), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .memW(memW),
    .muxRomRam(muxRomRam), .DIN(DIN), .LEDR(LEDR), .err(err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_rom [128];
  logic [15:0] m_ram [128];
  logic [15:0] m_din = 16'h0000, m_led = 16'h0000, m_rd = 16'h0000, m_wr = 16'h0000;
  logic        m_err = 1'b0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      m_rom[i] = 16'h0000;
      m_ram[i] = 16'h0000;
    end
  end

  // Applies one falling-edge memory transaction, or reset, to the model.
  initial begin
    forever begin
      @(negedge clk or posedge Resetn);
      if (Resetn) begin
        m_din = 16'h0000; m_led = 16'h0000; m_err = 1'b0;
        m_rd = 16'h0000; m_wr = 16'h0000;
      end else begin
        int unsigned a;
        a = ADDR;
        // read first, so a same-edge write is not visible
        if (!muxRomRam) begin
          if (a < 128) m_din = m_rom[a];
          else begin m_din = 16'h0000; m_err = 1'b1; end
        end else begin
          if (a < 128) m_din = m_ram[a];
          else if (a == 65535) m_din = m_led;
          else begin m_din = 16'h0000; m_err = 1'b1; end
`ifdef MEM_STATS_EN
          if (!memW && m_rd != 16'hFFFF) m_rd = m_rd + 1;
`endif
        end
        if (memW) begin
          if (a < 128 || a == 65535) begin
            if (a < 128) m_ram[a] = DOUT;
            else m_led = DOUT;
`ifdef MEM_STATS_EN
            if (m_wr != 16'hFFFF) m_wr = m_wr + 1;
`endif
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // Every cycle, away from the active (falling) edge, compare DUT and model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cmp_din", DIN, m_din);
      check("cmp_ledr", LEDR, m_led);
      check("cmp_err", {15'h0, err}, {15'h0, m_err});
      check("cmp_rd_cnt", rd_cnt, m_rd);
      check("cmp_wr_cnt", wr_cnt, m_wr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic w, input logic m, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #2;
    memW = w; muxRomRam = m; ADDR = a; DOUT = d;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    memW = 1'b0; muxRomRam = 1'b0; ADDR = 16'h0000;
    Resetn = 1'b1;
    settle();
    @(posedge clk);
    #2;
    Resetn = 1'b0;
  endtask

  // ROM image shared by DUT and model.
  task automatic load_rom(input int idx, input logic [15:0] val);
    dut.rom[idx] = val;
    m_rom[idx] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_cnt;
`ifdef MEM_STATS_EN
    exp_cnt = 16'h0001;
`else
    exp_cnt = 16'h0000;
`endif
    #1;
    Resetn = 1'b1;
    load_rom(0, 16'h1111);
    load_rom(3, 16'h0108);
    load_rom(127, 16'hABCD);
    repeat (2) @(posedge clk);
    #2;
    check("reset_din", DIN, 16'h0000);
    check("reset_err", {15'h0, err}, 16'h0000);
    Resetn = 1'b0;

    // 1: fetch from ROM word 3, then the last ROM word
    drive(1'b0, 1'b0, 16'd3, 16'h0000); settle();
    check("t1_din", DIN, 16'h0108);
    check("t1_err", {15'h0, err}, 16'h0000);
    drive(1'b0, 1'b0, 16'd127, 16'h0000); settle();
    check("t1_rom_last", DIN, 16'hABCD);

    // 2: store then load RAM[5]
    drive(1'b1, 1'b1, 16'd5, 16'h00AB); settle();
    drive(1'b0, 1'b1, 16'd5, 16'h0000); settle();
    check("t2_din", DIN, 16'h00AB);
    check("t2_wr_cnt", wr_cnt, exp_cnt);
    check("t2_rd_cnt", rd_cnt, exp_cnt);

    // 3: MMIO write then read back
    drive(1'b1, 1'b1, 16'hFFFF, 16'h1234); settle();
    check("t3_ledr", LEDR, 16'h1234);
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000); settle();
    check("t3_din", DIN, 16'h1234);

    // 5: read-before-write on RAM[7]
    drive(1'b1, 1'b1, 16'd7, 16'h0007); settle();
    drive(1'b1, 1'b1, 16'd7, 16'h0009); settle();
    check("t5_old", DIN, 16'h0007);
    drive(1'b0, 1'b1, 16'd7, 16'h0000); settle();
    check("t5_new", DIN, 16'h0009);

    // RAM upper boundary
    drive(1'b1, 1'b1, 16'd127, 16'h7F7F); settle();
    drive(1'b0, 1'b1, 16'd127, 16'h0000); settle();
    check("ram_last", DIN, 16'h7F7F);
    check("ram_last_err", {15'h0, err}, 16'h0000);

    // 4: out-of-range write, no aliasing, sticky err
    drive(1'b1, 1'b1, 16'h0200, 16'h5555); settle();
    check("t4_err", {15'h0, err}, 16'h0001);
    drive(1'b0, 1'b1, 16'h0000, 16'h0000); settle();
    check("t4_ram0", DIN, 16'h0000);
    drive(1'b1, 1'b1, 16'h0085, 16'hFFFF); settle();
    drive(1'b0, 1'b1, 16'd5, 16'h0000); settle();
    check("t4_no_alias", DIN, 16'h00AB);
    check("t4_sticky", {15'h0, err}, 16'h0001);
    pulse_reset();
    check("t4_err_clr", {15'h0, err}, 16'h0000);
    check("t4_ledr_clr", LEDR, 16'h0000);

    // out-of-range reads in both spaces
    drive(1'b0, 1'b0, 16'h0080, 16'h0000); settle();
    check("rom_oor_din", DIN, 16'h0000);
    check("rom_oor_err", {15'h0, err}, 16'h0001);
    drive(1'b0, 1'b1, 16'h0080, 16'h0000); settle();
    check("ram_oor_din", DIN, 16'h0000);

    // 6: reset raised mid-cycle during a write
    drive(1'b1, 1'b1, 16'd2, 16'h2222); settle();
    drive(1'b1, 1'b1, 16'd2, 16'hBEEF);
    #1;
    Resetn = 1'b1;
    settle();
    check("t6_din", DIN, 16'h0000);
    check("t6_ledr", LEDR, 16'h0000);
    check("t6_err", {15'h0, err}, 16'h0000);
    check("t6_rd_cnt", rd_cnt, 16'h0000);
    check("t6_wr_cnt", wr_cnt, 16'h0000);
    @(posedge clk);
    #2;
    memW = 1'b0; muxRomRam = 1'b1; ADDR = 16'd2;
    Resetn = 1'b0;
    settle();
    check("t6_ram2", DIN, 16'h2222);

    // ROM word 0 after everything else
    drive(1'b0, 1'b0, 16'd0, 16'h0000); settle();
    check("rom0", DIN, 16'h1111);

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
